// File: rtl/bcd_down_counter.sv
// Two-digit BCD down-counter stepped by a synchronized, edge-detected button; preset load, wrap/saturate at 00.
// Count, zero and borrow update 2 clk edges after the edge that first samples btn high; load acts on the next edge.
module bcd_down_counter #(
  parameter logic [3:0] RESET_TENS = 4'd9,
  parameter logic [3:0] RESET_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  input  logic       wrap_en,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       zero,
  output logic       borrow
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic       dec;
  logic [3:0] tens_nxt;
  logic [3:0] ones_nxt;
  logic       borrow_nxt;

  assign dec = sync2 & ~prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Load wins over a coincident decrement, which is dropped rather than queued.
  always_comb begin
    tens_nxt   = tens;
    ones_nxt   = ones;
    borrow_nxt = 1'b0;
    if (load) begin
      tens_nxt = (preset_tens > 4'd9) ? 4'd9 : preset_tens;
      ones_nxt = (preset_ones > 4'd9) ? 4'd9 : preset_ones;
    end else if (dec) begin
      if (ones != 4'd0) begin
        ones_nxt = ones - 4'd1;
      end else if (tens != 4'd0) begin
        ones_nxt = 4'd9;
        tens_nxt = tens - 4'd1;
      end else begin
        borrow_nxt = 1'b1;
        if (wrap_en) begin
          tens_nxt = 4'd9;
          ones_nxt = 4'd9;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens   <= RESET_TENS;
      ones   <= RESET_ONES;
      zero   <= (RESET_TENS == 4'd0) && (RESET_ONES == 4'd0);
      borrow <= 1'b0;
    end else begin
      tens   <= tens_nxt;
      ones   <= ones_nxt;
      zero   <= (tens_nxt == 4'd0) && (ones_nxt == 4'd0);
      borrow <= borrow_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter with hand-computed expected counts.
module tb_bcd_down_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] preset_tens = 4'd0;
  logic [3:0] preset_ones = 4'd0;
  logic       wrap_en = 1'b0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       zero;
  logic       borrow;

  int total = 0;
  int bad = 0;

  bcd_down_counter #(.RESET_TENS(4'd9), .RESET_ONES(4'd9)) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .load(load),
    .preset_tens(preset_tens),
    .preset_ones(preset_ones),
    .wrap_en(wrap_en),
    .tens(tens),
    .ones(ones),
    .zero(zero),
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] cnt, input logic z, input logic b);
    chk({tag, ".count"}, {tens, ones}, cnt);
    chk({tag, ".zero"}, {7'd0, zero}, {7'd0, z});
    chk({tag, ".borrow"}, {7'd0, borrow}, {7'd0, b});
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1;
    preset_tens = t;
    preset_ones = o;
    tick();
    load = 1'b0;
  endtask

  // Press with btn raised just after an edge; count updates on the third edge.
  task automatic press(input int hold);
    btn = 1'b1;
    ticks(hold);
    btn = 1'b0;
    ticks(3);
  endtask

  initial begin
    // Async reset before any clock edge
    #2;
    reset = 1'b1;
    #1;
    chk_state("reset_async", 8'h99, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    ticks(10);
    chk_state("idle_after_reset", 8'h99, 1'b0, 1'b0);

    // Load 10, then one long press, exact latency
    do_load(4'd1, 4'd0);
    chk_state("load10", 8'h10, 1'b0, 1'b0);
    btn = 1'b1;
    tick();
    chk("lat_edge1", {tens, ones}, 8'h10);
    tick();
    chk("lat_edge2", {tens, ones}, 8'h10);
    tick();
    chk_state("lat_edge3", 8'h09, 1'b0, 1'b0);
    ticks(17);
    chk("held_single_dec", {tens, ones}, 8'h09);
    btn = 1'b0;
    ticks(3);
    press(5);
    chk_state("second_press", 8'h08, 1'b0, 1'b0);

    // Wrap: 01 -> 00 -> 99 with one-cycle borrow
    wrap_en = 1'b1;
    do_load(4'd0, 4'd1);
    press(4);
    chk_state("wrap_to00", 8'h00, 1'b1, 1'b0);
    btn = 1'b1;
    ticks(3);
    chk_state("wrap_to99", 8'h99, 1'b0, 1'b1);
    tick();
    chk_state("wrap_borrow_end", 8'h99, 1'b0, 1'b0);
    btn = 1'b0;
    ticks(3);

    // Saturate at 00: three presses, three single-cycle borrows
    wrap_en = 1'b0;
    do_load(4'd0, 4'd0);
    chk_state("sat_load00", 8'h00, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      btn = 1'b1;
      ticks(2);
      chk_state("sat_pre", 8'h00, 1'b1, 1'b0);
      tick();
      chk_state("sat_borrow", 8'h00, 1'b1, 1'b1);
      tick();
      chk_state("sat_borrow_end", 8'h00, 1'b1, 1'b0);
      btn = 1'b0;
      ticks(3);
    end

    // Load coinciding with dec at 00: clamp, no decrement, no borrow
    btn = 1'b1;
    ticks(2);
    load = 1'b1;
    preset_tens = 4'hC;
    preset_ones = 4'h5;
    tick();
    load = 1'b0;
    chk_state("load_clamp_prio", 8'h95, 1'b0, 1'b0);
    ticks(4);
    chk("load_dec_dropped", {tens, ones}, 8'h95);
    btn = 1'b0;
    ticks(3);
    press(3);
    chk_state("after_load_press", 8'h94, 1'b0, 1'b0);

    // Reset while dec is high at 37
    do_load(4'd3, 4'd7);
    chk("load37", {tens, ones}, 8'h37);
    btn = 1'b1;
    ticks(2);
    reset = 1'b1;
    #1;
    chk_state("reset_mid", 8'h99, 1'b0, 1'b0);
    btn = 1'b0;
    tick();
    reset = 1'b0;
    ticks(6);
    chk_state("reset_no_residual", 8'h99, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Two-digit BCD decade down-counter. It mirrors the team's button-clocked modulo-10 up-counter and counts the other direction. One raw button level decrements the count by one per press. The block runs from a single system clock rather than from the button. It supplies preset/load, wrap or saturate at 00, a zero flag and a one-cycle borrow pulse, so it can drive LEDs or cascade into a further stage.

## Interface
- RESET_TENS, 9, tens digit loaded on reset (0..9)
- RESET_ONES, 9, ones digit loaded on reset (0..9)
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; one clock, async active-high reset (fixed)
- btn  input  1  raw, asynchronous button level; each 0->1 transition requests one decrement
- load  input  1  synchronous load of preset digits
- preset_tens  input  4  tens digit for load
- preset_ones  input  4  ones digit for load
- wrap_en  input  1  1: 00 wraps to 99; 0: 00 holds (saturate)
- tens  output  4  current tens digit, always 0..9
- ones  output  4  current ones digit, always 0..9
- zero  output  1  high while count == 00 (registered)
- borrow  output  1  one-cycle pulse on a decrement attempted at 00

## Operation
- Input conditioning:
  - btn passes through a two-flop synchronizer, sync1 then sync2.
  - A third flop, prev, holds the last sync2.
  - dec = sync2 & ~prev. Exactly one dec cycle per btn rising edge, regardless of how long btn is held.
- Priority per clock: reset > load > dec > hold.
- Load:
  - tens <= preset_tens, ones <= preset_ones.
  - Any preset digit > 9 is clamped to 9.
  - A dec coinciding with load is discarded, not deferred.
- Decrement, count != 00:
  - ones != 0: ones <= ones-1.
  - ones == 0: ones <= 9, tens <= tens-1.
- Decrement, count == 00:
  - wrap_en=1: count <= 99, borrow <= 1 for one cycle.
  - wrap_en=0: count stays 00, borrow <= 1 for one cycle.
- zero is registered. It is computed from the next-state count, so it is valid in the same cycle as the new digits.
- borrow is 0 in every cycle with no dec at 00, including load cycles.
- Arithmetic is per-digit 4-bit BCD with no binary carry across digits. Digits never leave 0..9.
- Reset (async assert, any time including mid-decrement):
  - tens=RESET_TENS, ones=RESET_ONES.
  - zero=1 iff both reset digits are 0, else 0.
  - borrow=0; sync1, sync2 and prev all 0.
  - A btn held high through reset release therefore produces one dec after release.
- Reset deassertion is assumed to be synchronized externally to clk.

## Timing
- Reset asserting is asynchronous: outputs take reset values immediately, without waiting for a clk edge.
- btn latency:
  - Let E0 be the first clk edge at which sync1 samples btn=1.
  - sync2=1 after E0+1, so dec is high for the cycle E0+1..E0+2.
  - tens, ones, zero and borrow update at E0+2. Latency is 2 edges (3 counting the sampling edge); throughput is one decrement per btn high/low cycle.
- btn pulses narrower than one clk period may be missed. This is acceptable.
- btn must be low for at least 2 clk cycles between presses for the presses to count separately.
- load is not synchronized. It acts at the first rising edge where it is sampled high, with 1-edge latency, and repeats each cycle it is held.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
- Reset: assert reset with RESET=99 -> tens=9, ones=9, zero=0, borrow=0 immediately, before any clk edge. Release, hold btn=0 for 10 cycles -> no change.
- Basic decrement and digit borrow: load 10, one btn press held 20 cycles -> exactly one decrement, 10->09 exactly 2 edges after the sampling edge. Second press -> 08.
- Wrap: wrap_en=1, load 01, two presses -> 00 (zero=1), then 99 (zero=0) with borrow high for exactly one cycle.
- Saturate: wrap_en=0 at 00, three presses -> stays 00, zero=1 throughout, three separate single-cycle borrow pulses.
- Load priority and clamp: load preset 0xC/0x5 in the same cycle dec is high -> count=95, no decrement, borrow=0. The next press -> 94.
- Reset mid-operation: assert reset in the cycle dec is high at count 37 -> count=99, borrow=0, no residual decrement after release while btn stays low.
